// File: rtl/mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_ctrl                                                         |
// | Brief   : arbitrates fetch and load/store requests onto a byte-wide bus.   |
// | Option  : MEM_CTRL_STORE_POST_EN - store ack after the first byte.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mem_ctrl #(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic        ls_signed,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // The IO window sits in mem_addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]; it must fit in 32 bits.
  if (RAM_ADDR_WIDTH < 1 || RAM_ADDR_WIDTH > 31) begin : g_bad_addr_width
    $error("mem_ctrl: RAM_ADDR_WIDTH out of range");
  end

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [2:0]  r_cnt;
  logic [2:0]  r_len;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_is_ls;

  logic [31:0] w_buf_next;
  logic [31:0] w_ext;
  logic [7:0]  w_wbyte;
  logic [1:0]  w_cap_idx;

  function automatic logic [2:0] f_len(input logic [1:0] size);
    case (size)
      2'd0:    f_len = 3'd1;
      2'd1:    f_len = 3'd2;
      default: f_len = 3'd4;
    endcase
  endfunction

  // Byte issued at count c returns on mem_din two edges later, at count c+2.
  assign w_cap_idx = r_cnt[1:0] - 2'd2;
  assign w_wbyte   = r_wdata[{r_cnt[1:0], 3'b000} +: 8];

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[{w_cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    case (r_size)
      2'd0:    w_ext = {{24{r_signed & w_buf_next[7]}}, w_buf_next[7:0]};
      2'd1:    w_ext = {{16{r_signed & w_buf_next[15]}}, w_buf_next[15:0]};
      default: w_ext = w_buf_next;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= IDLE;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_buf    <= 32'd0;
      r_cnt    <= 3'd0;
      r_len    <= 3'd0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_is_ls  <= 1'b0;
      if_ack   <= 1'b0;
      if_data  <= 32'd0;
      ls_ack   <= 1'b0;
      ls_rdata <= 32'd0;
      mem_dout <= 8'd0;
      mem_addr <= 32'd0;
      mem_wr   <= 1'b0;
      busy     <= 1'b0;
    end else if (rdy_in) begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ls_req) begin
            r_is_ls  <= 1'b1;
            r_addr   <= ls_addr;
            r_wdata  <= ls_wdata;
            r_size   <= ls_size;
            r_signed <= ls_signed;
            r_len    <= f_len(ls_size);
            r_cnt    <= 3'd1;
            mem_addr <= ls_addr;
            busy     <= 1'b1;
            if (ls_wr) begin
              r_state  <= WR;
              mem_wr   <= 1'b1;
              mem_dout <= ls_wdata[7:0];
            end else begin
              r_state  <= RD;
            end
          end else if (if_req) begin
            r_is_ls  <= 1'b0;
            r_addr   <= if_addr;
            r_size   <= 2'd2;
            r_signed <= 1'b0;
            r_len    <= 3'd4;
            r_cnt    <= 3'd1;
            mem_addr <= if_addr;
            busy     <= 1'b1;
            r_state  <= RD;
          end
        end
        RD: begin
          mem_addr <= (r_cnt < r_len) ? r_addr + {29'd0, r_cnt} : 32'd0;
          if (r_cnt >= 3'd2) r_buf <= w_buf_next;
          if (r_cnt == r_len + 3'd1) begin
            r_state <= DONE;
            r_cnt   <= 3'd0;
            if (r_is_ls) begin
              ls_ack   <= 1'b1;
              ls_rdata <= w_ext;
            end else begin
              if_ack  <= 1'b1;
              if_data <= w_buf_next;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        WR: begin
          if (r_cnt < r_len) begin
            mem_addr <= r_addr + {29'd0, r_cnt};
            mem_dout <= w_wbyte;
            mem_wr   <= 1'b1;
          end else begin
            mem_addr <= 32'd0;
            mem_dout <= 8'd0;
            mem_wr   <= 1'b0;
          end
`ifdef MEM_CTRL_STORE_POST_EN
          if (r_cnt == 3'd1) ls_ack <= 1'b1;
`endif
          if (r_cnt == r_len) begin
            r_state <= DONE;
            r_cnt   <= 3'd0;
`ifndef MEM_CTRL_STORE_POST_EN
            ls_ack  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        DONE: begin
          r_state  <= IDLE;
          busy     <= 1'b0;
          mem_addr <= 32'd0;
          mem_dout <= 8'd0;
          mem_wr   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
